sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port byte-write SRAM (1-cycle registered read, output forced to 0 when not enabled) between two requesters:
  - an instruction-fetch port (I, read-only);
  - a data port (D, read/byte-write).
- Arbitrates each cycle and drives the SRAM enable, address, byte-enables and write data.
- Routes the read data, one cycle later, back to the requester that was granted.
- Fully pipelined: one access per cycle. Sits between the core bus adapters and the SRAM.

Parameters:
- NB_COL, 4, bytes per word (byte-enable width)
- COL_WIDTH, 8, bits per byte lane
- RAM_DEPTH, 8192, SRAM words
- AW, 13, word-address width; must equal ceil(log2(RAM_DEPTH))
- MAX_BURST, 4, max consecutive D grants while I waits (fixed-priority mode); 0 = unlimited

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  I request
- i_req_ready  out  1  I request accepted this cycle
- i_req_addr  in  AW  I word address
- i_rsp_valid  out  1  I read data valid
- i_rsp_rdata  out  NB_COL*COL_WIDTH  I read data
- d_req_valid  in  1  D request
- d_req_ready  out  1  D request accepted this cycle
- d_req_addr  in  AW  D word address
- d_req_wdata  in  NB_COL*COL_WIDTH  D write data
- d_req_wstrb  in  NB_COL  D byte strobes; all-zero = read
- d_rsp_valid  out  1  D response (read data or write ack)
- d_rsp_rdata  out  NB_COL*COL_WIDTH  D read data
- sram_ena  out  1  SRAM enable
- sram_addr  out  AW  SRAM address
- sram_wea  out  NB_COL  SRAM byte-write enables
- sram_wdata  out  NB_COL*COL_WIDTH  SRAM write data
- sram_rdata  in  NB_COL*COL_WIDTH  SRAM read data (registered in SRAM)

Behaviour:
- Reset (async assert, sync release) clears internal state:
  - response-owner flags = 0;
  - burst counter = 0;
  - RR pointer = "last=I".
- Under reset: i_rsp_valid = d_rsp_valid = 0 and both rsp_rdata = 0. Ready/SRAM outputs follow the combinational arbitration below.
- Arbitration is combinational in cycle N:
  - Accept = valid && ready.
  - At most one ready high per cycle.
  - Ready never asserted without its own valid.
- Single requester valid → that requester is granted.
- Both valid, fixed-priority mode (macro off):
  - D wins unless burst counter == MAX_BURST (MAX_BURST ≠ 0); then I wins.
- Burst counter:
  - +1 on a D grant while i_req_valid = 1, saturating at MAX_BURST.
  - Cleared on an I grant or in any cycle with i_req_valid = 0.
- SRAM drive in cycle N:
  - sram_ena = any accept.
  - sram_addr = granted address.
  - sram_wea = d_req_wstrb if D granted, else 0.
  - sram_wdata = d_req_wdata if D granted, else 0.
  - Idle: all SRAM outputs 0.
- Response registers, set in cycle N, active in cycle N+1:
  - i_rsp_valid = 1 in N+1 iff I accepted in N.
  - d_rsp_valid = 1 in N+1 iff D accepted in N; this applies to reads and writes.
  - x_rsp_rdata = sram_rdata when x_rsp_valid, else 0.
  - For a D write response, d_rsp_rdata is don't-care; the bench must not check it.
- Back-to-back:
  - Grants in N and N+1 give responses in N+1 and N+2.
  - No bubbles, no response backpressure. Requesters must sink responses.
- Requests may change address/data any cycle while not accepted; no stability requirement.
- Reset mid-operation: a pending response is dropped (no rsp_valid after release).

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: contention resolved round-robin.
  - 1-bit pointer holds the last granted port; updated on every grant, including uncontended ones.
  - When both ports are valid, the port not last granted wins.
  - Reset "last=I", so the first contention goes to D.
  - MAX_BURST and the burst counter are unused; the counter is held at 0.
- Undefined: fixed-priority with MAX_BURST limit as above.

Test Plan:
- Reset, then D write addr 0x010, wdata 0xDEADBEEF, wstrb 0xF; next cycle D read 0x010 → sram_wea = 0xF in write cycle; d_rsp_valid on both following cycles; second d_rsp_rdata = 0xDEADBEEF.
- Byte write wstrb 0x2, wdata 0x0000AB00 over 0x11223344 at 0x020; I reads 0x020 → i_rsp_rdata = 0x1122AB44 one cycle after i_req_ready.
- Fixed-priority, MAX_BURST = 4, both valid continuously for 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I; responses land on the correct port each one cycle later.
- With SRAM_ARB_RR_EN, both valid 6 cycles → D,I,D,I,D,I; then I only for 2 cycles → I,I; then both valid → D.
- No requests → sram_ena = 0, sram_wea = 0, both rsp_valid = 0, rsp_rdata = 0 every cycle.
- Assert rst_n = 0 the cycle after an I accept → i_rsp_valid stays 0 immediately and after release; the first post-reset contention goes to D.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port byte-write SRAM.
// Optional build macro SRAM_ARB_RR_EN: round-robin contention instead of fixed-priority.
module sram_port_arbiter #(
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 8192,
  parameter int unsigned AW        = 13,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_valid,
  output logic                          i_req_ready,
  input  logic [AW-1:0]                 i_req_addr,
  output logic                          i_rsp_valid,
  output logic [NB_COL*COL_WIDTH-1:0]   i_rsp_rdata,
  input  logic                          d_req_valid,
  output logic                          d_req_ready,
  input  logic [AW-1:0]                 d_req_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   d_req_wdata,
  input  logic [NB_COL-1:0]             d_req_wstrb,
  output logic                          d_rsp_valid,
  output logic [NB_COL*COL_WIDTH-1:0]   d_rsp_rdata,
  output logic                          sram_ena,
  output logic [AW-1:0]                 sram_addr,
  output logic [NB_COL-1:0]             sram_wea,
  output logic [NB_COL*COL_WIDTH-1:0]   sram_wdata,
  input  logic [NB_COL*COL_WIDTH-1:0]   sram_rdata
);

  localparam int unsigned DW = NB_COL * COL_WIDTH;

  if (AW != $clog2(RAM_DEPTH)) begin : g_bad_aw
    $error("AW must equal clog2(RAM_DEPTH)");
  end

  logic i_gnt, d_gnt;
  logic i_own_q, d_own_q;

`ifdef SRAM_ARB_RR_EN
  // 1 = data port was granted last
  logic last_d_q, last_d_d;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req_valid && d_req_valid) begin
      if (last_d_q) i_gnt = 1'b1;
      else          d_gnt = 1'b1;
    end else begin
      i_gnt = i_req_valid;
      d_gnt = d_req_valid;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (d_gnt)      last_d_d = 1'b1;
    else if (i_gnt) last_d_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  localparam int unsigned BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  logic [BW-1:0] burst_q, burst_d;
  logic          burst_full;

  assign burst_full = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST));

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req_valid && d_req_valid) begin
      if (burst_full) i_gnt = 1'b1;
      else            d_gnt = 1'b1;
    end else begin
      i_gnt = i_req_valid;
      d_gnt = d_req_valid;
    end
  end

  // Counts D grants that made a waiting I requester wait; saturates at MAX_BURST.
  always_comb begin
    burst_d = burst_q;
    if (!i_req_valid || i_gnt) begin
      burst_d = '0;
    end else if (d_gnt && (burst_q != BW'(MAX_BURST))) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_q <= '0;
    else        burst_q <= burst_d;
  end
`endif

  assign i_req_ready = i_gnt;
  assign d_req_ready = d_gnt;

  always_comb begin
    sram_ena   = i_gnt | d_gnt;
    sram_addr  = '0;
    sram_wea   = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_addr  = d_req_addr;
      sram_wea   = d_req_wstrb;
      sram_wdata = d_req_wdata;
    end else if (i_gnt) begin
      sram_addr = i_req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_own_q <= 1'b0;
      d_own_q <= 1'b0;
    end else begin
      i_own_q <= i_gnt;
      d_own_q <= d_gnt;
    end
  end

  assign i_rsp_valid = i_own_q;
  assign d_rsp_valid = d_own_q;
  assign i_rsp_rdata = i_own_q ? sram_rdata : DW'(0);
  assign d_rsp_rdata = d_own_q ? sram_rdata : DW'(0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural byte-write SRAM.
// Expected contention order follows SRAM_ARB_RR_EN when defined.
module tb_sram_port_arbiter;

  localparam int unsigned NB_COL    = 4;
  localparam int unsigned COL_WIDTH = 8;
  localparam int unsigned RAM_DEPTH = 8192;
  localparam int unsigned AW        = 13;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned DW        = NB_COL * COL_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0]     i_req_addr;
  logic [DW-1:0]     i_rsp_rdata;
  logic              d_req_valid, d_req_ready, d_rsp_valid;
  logic [AW-1:0]     d_req_addr;
  logic [DW-1:0]     d_req_wdata, d_rsp_rdata;
  logic [NB_COL-1:0] d_req_wstrb;
  logic              sram_ena;
  logic [AW-1:0]     sram_addr;
  logic [NB_COL-1:0] sram_wea;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata = '0;
  logic [DW-1:0]     mem [0:RAM_DEPTH-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(RAM_DEPTH), .AW(AW),
    .MAX_BURST(MAX_BURST)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .sram_ena(sram_ena), .sram_addr(sram_addr), .sram_wea(sram_wea),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM: registered read-first, output zero when not enabled
  always @(posedge clk) begin
    if (sram_ena) begin
      for (int b = 0; b < NB_COL; b++) begin
        if (sram_wea[b]) mem[sram_addr][b*COL_WIDTH +: COL_WIDTH] <= sram_wdata[b*COL_WIDTH +: COL_WIDTH];
      end
      sram_rdata <= mem[sram_addr];
    end else begin
      sram_rdata <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [AW-1:0] ia, input logic dv,
                       input logic [AW-1:0] da, input logic [DW-1:0] dw,
                       input logic [NB_COL-1:0] ds);
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_addr  = da;
    d_req_wdata = dw;
    d_req_wstrb = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef SRAM_ARB_RR_EN
  localparam int NCONT = 6;
  logic [9:0] seq = 10'b0000010101;
`else
  localparam int NCONT = 10;
  logic [9:0] seq = 10'b0111101111;
`endif

  initial begin
    drive(1'b0, 13'h0, 1'b0, 13'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_i_rdata", i_rsp_rdata, 32'h0);
    check("rst_d_rdata", d_rsp_rdata, 32'h0);
    check("rst_ena", 32'(sram_ena), 32'd0);
    rst_n = 1'b1;
    tick();

    // D write then D read back
    drive(1'b0, 13'h0, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF);
    #1;
    check("wr_d_ready", 32'(d_req_ready), 32'd1);
    check("wr_i_ready", 32'(i_req_ready), 32'd0);
    check("wr_wea", 32'(sram_wea), 32'hF);
    check("wr_addr", 32'(sram_addr), 32'h010);
    check("wr_wdata", sram_wdata, 32'hDEADBEEF);
    tick();
    check("wr_rsp_valid", 32'(d_rsp_valid), 32'd1);
    drive(1'b0, 13'h0, 1'b1, 13'h010, 32'h0, 4'h0);
    #1;
    check("rd_wea", 32'(sram_wea), 32'h0);
    tick();
    check("rd_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("rd_rdata", d_rsp_rdata, 32'hDEADBEEF);
    check("rd_i_rsp_valid", 32'(i_rsp_valid), 32'd0);

    // Partial byte write, then I fetch
    drive(1'b0, 13'h0, 1'b1, 13'h020, 32'h11223344, 4'hF);
    tick();
    drive(1'b0, 13'h0, 1'b1, 13'h020, 32'h0000AB00, 4'h2);
    #1;
    check("bw_wea", 32'(sram_wea), 32'h2);
    tick();
    drive(1'b1, 13'h020, 1'b0, 13'h0, 32'h0, 4'h0);
    #1;
    check("if_i_ready", 32'(i_req_ready), 32'd1);
    check("if_d_ready", 32'(d_req_ready), 32'd0);
    check("if_wea", 32'(sram_wea), 32'h0);
    tick();
    check("if_rsp_valid", 32'(i_rsp_valid), 32'd1);
    check("if_rdata", i_rsp_rdata, 32'h1122AB44);
    check("if_d_rsp_valid", 32'(d_rsp_valid), 32'd0);

    // Idle
    drive(1'b0, 13'h0, 1'b0, 13'h0, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("idle_ena", 32'(sram_ena), 32'd0);
      check("idle_wea", 32'(sram_wea), 32'h0);
      check("idle_addr", 32'(sram_addr), 32'h0);
      tick();
      check("idle_i_rsp", 32'(i_rsp_valid), 32'd0);
      check("idle_d_rsp", 32'(d_rsp_valid), 32'd0);
      check("idle_i_rdata", i_rsp_rdata, 32'h0);
      check("idle_d_rdata", d_rsp_rdata, 32'h0);
    end

    // Contention: D reads 0x010, I reads 0x020
    drive(1'b1, 13'h020, 1'b1, 13'h010, 32'h0, 4'h0);
    for (int c = 0; c < NCONT; c++) begin
      #1;
      check($sformatf("cont%0d_d_ready", c), 32'(d_req_ready), 32'(seq[c]));
      check($sformatf("cont%0d_i_ready", c), 32'(i_req_ready), 32'(!seq[c]));
      tick();
      check($sformatf("cont%0d_d_rsp", c), 32'(d_rsp_valid), 32'(seq[c]));
      check($sformatf("cont%0d_i_rsp", c), 32'(i_rsp_valid), 32'(!seq[c]));
      if (seq[c]) begin
        check($sformatf("cont%0d_d_rdata", c), d_rsp_rdata, 32'hDEADBEEF);
        check($sformatf("cont%0d_i_rdata", c), i_rsp_rdata, 32'h0);
      end else begin
        check($sformatf("cont%0d_i_rdata", c), i_rsp_rdata, 32'h1122AB44);
        check($sformatf("cont%0d_d_rdata", c), d_rsp_rdata, 32'h0);
      end
    end

    // I alone twice, then contention goes to D
    drive(1'b1, 13'h020, 1'b0, 13'h0, 32'h0, 4'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("ionly_i_ready", 32'(i_req_ready), 32'd1);
      tick();
      check("ionly_i_rsp", 32'(i_rsp_valid), 32'd1);
    end
    drive(1'b1, 13'h020, 1'b1, 13'h010, 32'h0, 4'h0);
    #1;
    check("post_ionly_d_ready", 32'(d_req_ready), 32'd1);
    check("post_ionly_i_ready", 32'(i_req_ready), 32'd0);
    tick();

    // Reset right after an I accept drops the pending response
    drive(1'b1, 13'h020, 1'b0, 13'h0, 32'h0, 4'h0);
    #1;
    check("mid_i_ready", 32'(i_req_ready), 32'd1);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 13'h0, 1'b0, 13'h0, 32'h0, 4'h0);
    #1;
    check("mid_rst_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("mid_rst_i_rdata", i_rsp_rdata, 32'h0);
    tick();
    check("mid_rst_i_rsp2", 32'(i_rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("mid_rel_d_rsp", 32'(d_rsp_valid), 32'd0);
    drive(1'b1, 13'h020, 1'b1, 13'h010, 32'h0, 4'h0);
    #1;
    check("mid_first_d_ready", 32'(d_req_ready), 32'd1);
    check("mid_first_i_ready", 32'(i_req_ready), 32'd0);
    tick();
    check("mid_first_d_rsp", 32'(d_rsp_valid), 32'd1);
    drive(1'b0, 13'h0, 1'b0, 13'h0, 32'h0, 4'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
